regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_clr_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the operand register file,
// also consumed by decode and ALU.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 6;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: one write port, NRD packed read ports,
// and the clear-sweep request/busy pair.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2
);

  logic                    clr_req;
  logic                    busy;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [DATA_W-1:0]       wd;
  logic [NRD*ADDR_W-1:0]   ra;
  logic [NRD*DATA_W-1:0]   rd;

  modport master (
    output clr_req, we, wa, wd, ra,
    input  busy, rd
  );

  modport slave (
    input  clr_req, we, wa, wd, ra,
    output busy, rd
  );

endinterface : regfile_mp_if

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep sequencer: walks every address once after reset or on request,
// emitting a zero-write strobe and holding busy for the whole sweep.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  // One extra bit keeps the terminal compare clear of wrap-around.
  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CLR_STEP = {{ADDR_W{1'b0}}, 1'b1};

  rf_state_e         state_q;
  logic [ADDR_W:0]   clr_addr_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RF_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          if (clr_addr_q == CLR_LAST) begin
            state_q    <= RF_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + CLR_STEP;
          end
        end
        RF_IDLE: begin
          if (clr_req_i) begin
            state_q    <= RF_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= RF_CLEAR;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = clr_addr_q[ADDR_W-1:0];

endmodule : regfile_clr_fsm

// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write bypass, optional
// hard-wired zero register and a sequential clear sweep (array has no reset).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ext_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NRD-1:0][DATA_W-1:0] rd_arr;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign bus.busy = busy;

  // Qualified external write: also drives the bypass, so a discarded
  // zero-register write never forwards.
  assign ext_we = bus.we && !busy && !(ZERO_REG && (bus.wa == '0));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (ext_we) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra_w;
      logic [DATA_W-1:0] rd_w;

      assign ra_w = bus.ra[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_w = mem_q[ra_w];
        if (busy) begin
          rd_w = '0;
        end else if (ZERO_REG && (ra_w == '0)) begin
          rd_w = '0;
        end else if (ext_we && (bus.wa == ra_w)) begin
          rd_w = bus.wd;
        end
      end

      assign rd_arr[gi] = rd_w;
    end
  endgenerate

  assign bus.rd = rd_arr;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp: a 64x32 two-port instance
// with zero register and a 16x16 four-port instance without.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(6), .NRD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NRD(4)) bus_b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(6), .NRD(2), .ZERO_REG(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NRD(4), .ZERO_REG(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: register contents plus edges left in the current sweep.
  logic [31:0] ref_a [64];
  logic [15:0] ref_b [16];
  int left_a = 64;
  int left_b = 16;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    logic [5:0]  ra;
    logic [31:0] e;
    logic        bsy;
    bsy = !rst_n || (left_a > 0);
    chk("a_busy", 64'(bus_a.busy), 64'(bsy));
    for (int p = 0; p < 2; p++) begin
      ra = bus_a.ra[p*6 +: 6];
      if (bsy || ra == 6'd0)                  e = '0;
      else if (bus_a.we && bus_a.wa == ra)    e = bus_a.wd;
      else                                    e = ref_a[ra];
      chk($sformatf("a_rd%0d@%0d", p, ra), 64'(bus_a.rd[p*32 +: 32]), 64'(e));
    end
  endtask

  task automatic check_b();
    logic [3:0]  ra;
    logic [15:0] e;
    logic        bsy;
    bsy = !rst_n || (left_b > 0);
    chk("b_busy", 64'(bus_b.busy), 64'(bsy));
    for (int p = 0; p < 4; p++) begin
      ra = bus_b.ra[p*4 +: 4];
      if (bsy)                                e = '0;
      else if (bus_b.we && bus_b.wa == ra)    e = bus_b.wd;
      else                                    e = ref_b[ra];
      chk($sformatf("b_rd%0d@%0d", p, ra), 64'(bus_b.rd[p*16 +: 16]), 64'(e));
    end
  endtask

  task automatic edge_a();
    if (left_a > 0) begin
      left_a--;
      if (left_a == 0) foreach (ref_a[i]) ref_a[i] = '0;
    end else begin
      if (bus_a.we && bus_a.wa != 6'd0) ref_a[bus_a.wa] = bus_a.wd;
      if (bus_a.clr_req) left_a = 64;
    end
  endtask

  task automatic edge_b();
    if (left_b > 0) begin
      left_b--;
      if (left_b == 0) foreach (ref_b[i]) ref_b[i] = '0;
    end else begin
      if (bus_b.we) ref_b[bus_b.wa] = bus_b.wd;
      if (bus_b.clr_req) left_b = 16;
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later.
  task automatic tick();
    #1;
    check_a();
    check_b();
    if (rst_n) begin
      edge_a();
      edge_b();
    end
    @(negedge clk);
  endtask

  task automatic rand_a(input int clr_odds);
    logic [5:0] a0, a1;
    bus_a.we = 1'($urandom_range(0, 1));
    bus_a.wa = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
    bus_a.wd = $urandom;
    a0 = ($urandom_range(0, 2) == 0) ? bus_a.wa : 6'($urandom);
    a1 = ($urandom_range(0, 2) == 0) ? bus_a.wa : 6'($urandom);
    bus_a.ra = {a1, a0};
    bus_a.clr_req = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
  endtask

  task automatic rand_b(input int clr_odds);
    logic [3:0] a [4];
    bus_b.we = 1'($urandom_range(0, 1));
    bus_b.wa = 4'($urandom);
    bus_b.wd = 16'($urandom);
    foreach (a[i]) a[i] = ($urandom_range(0, 2) == 0) ? bus_b.wa : 4'($urandom);
    bus_b.ra = {a[3], a[2], a[1], a[0]};
    bus_b.clr_req = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
  endtask

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra = '0; bus_a.clr_req = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.we = 1'b0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra = '0; bus_b.clr_req = 1'b0;
  endtask

  task automatic release_reset();
    rst_n  = 1'b1;
    left_a = 64;
    left_b = 16;
  endtask

  initial begin
    logic [3:0] base;
    foreach (ref_a[i]) ref_a[i] = '0;
    foreach (ref_b[i]) ref_b[i] = '0;
    idle_a();
    idle_b();

    // Reset held: busy=1 and all reads 0.
    @(negedge clk);
    repeat (3) tick();
    release_reset();

    // Post-reset sweep; a write to reg 5 mid-sweep must be dropped.
    for (int i = 0; i < 66; i++) begin
      idle_a();
      if (i == 3) begin
        bus_a.we = 1'b1; bus_a.wa = 6'd5; bus_a.wd = 32'hDEADBEEF;
      end
      bus_a.ra = {6'($urandom), 6'd5};
      tick();
    end

    // Every register reads 0 after the sweep.
    for (int a = 0; a < 64; a += 2) begin
      idle_a();
      bus_a.ra = {6'(a + 1), 6'(a)};
      tick();
    end

    // Write bypass, then the stored value from the array.
    bus_a.we = 1'b1; bus_a.wa = 6'd7; bus_a.wd = 32'h12345678; bus_a.ra = {6'd7, 6'd7};
    tick();
    bus_a.we = 1'b0;
    tick();

    // Zero-register write is discarded (and not forwarded).
    bus_a.we = 1'b1; bus_a.wa = 6'd0; bus_a.wd = 32'hFFFFFFFF; bus_a.ra = {6'd0, 6'd0};
    tick();
    bus_a.we = 1'b0;
    tick();

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      rand_a(50);
      tick();
    end
    idle_a();
    while (left_a > 0) tick();

    // Directed clear with a redundant request at sweep edge 10.
    bus_a.we = 1'b1; bus_a.wa = 6'd3;  bus_a.wd = 32'hA; tick();
    bus_a.wa = 6'd63; bus_a.wd = 32'hB; bus_a.ra = {6'd63, 6'd3}; tick();
    bus_a.we = 1'b0; bus_a.clr_req = 1'b1; tick();
    for (int i = 1; i <= 70; i++) begin
      bus_a.clr_req = (i == 10);
      tick();
    end

    // Reset asserted at sweep edge 20; a full sweep follows release.
    idle_a();
    bus_a.clr_req = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      rand_a(4);
      tick();
    end
    rst_n = 1'b0;
    repeat (3) tick();
    release_reset();
    for (int i = 0; i < 80; i++) begin
      rand_a(0);
      tick();
    end

    // Four-port instance: fill all registers with distinct values.
    idle_a();
    for (int i = 0; i < 16; i++) begin
      bus_b.we = 1'b1; bus_b.wa = 4'(i); bus_b.wd = 16'(i * 257 + 3); bus_b.clr_req = 1'b0;
      bus_b.ra = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      tick();
    end
    bus_b.we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      base = 4'($urandom);
      bus_b.ra = {base + 4'd11, base + 4'd7, base + 4'd3, base};
      tick();
    end

    // All ports on the address being written, including register 0.
    for (int i = 0; i < 8; i++) begin
      bus_b.we = 1'b1;
      bus_b.wa = (i == 0) ? 4'd0 : 4'($urandom);
      bus_b.wd = (i == 0) ? 16'hFFFF : 16'($urandom);
      bus_b.ra = {4{bus_b.wa}};
      tick();
      bus_b.we = 1'b0;
      tick();
    end

    for (int i = 0; i < 150; i++) begin
      rand_b(30);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
